register_file_vectorial_stream: RTL

- Parametrised next-generation vector register file for the vector datapath.
- Two combinational read ports and one full-vector write port with per-lane write mask and broadcast mode.
- Write-first bypass on both read ports.
- Additional element-serial load port: a small FSM fills one vector register one element per handshake, for memory-to-VRF loads.

---
 rtl/register_file_vectorial_stream_if.sv | 39 +++
 rtl/register_file_vectorial_stream.sv | 111 +++++++++++
 2 files changed

// File: rtl/register_file_vectorial_stream_if.sv
// Bus bundle for the vector register file: two read ports, one masked/broadcast
// vector write port and the element-serial load handshake.
interface register_file_vectorial_stream_if #(
    parameter int WIDTH        = 32,
    parameter int VECTOR_SIZE  = 16,
    parameter int NUM_VECTORES = 8
);
    localparam int IDX_W = $clog2(NUM_VECTORES);
    localparam int VEC_W = WIDTH * VECTOR_SIZE;

    logic                   we3;
    logic [IDX_W-1:0]       v1;
    logic [IDX_W-1:0]       v2;
    logic [IDX_W-1:0]       v3;
    logic [VEC_W-1:0]       wd3;
    logic [VECTOR_SIZE-1:0] wmask;
    logic                   bcast;
    logic [VEC_W-1:0]       vd1;
    logic [VEC_W-1:0]       vd2;
    logic                   st_start;
    logic [IDX_W-1:0]       st_v;
    logic                   st_valid;
    logic [WIDTH-1:0]       st_data;
    logic                   st_ready;
    logic                   st_busy;
    logic                   st_done;

    modport master (
        output we3, v1, v2, v3, wd3, wmask, bcast,
        output st_start, st_v, st_valid, st_data,
        input  vd1, vd2, st_ready, st_busy, st_done
    );

    modport slave (
        input  we3, v1, v2, v3, wd3, wmask, bcast,
        input  st_start, st_v, st_valid, st_data,
        output vd1, vd2, st_ready, st_busy, st_done
    );
endinterface

// File: rtl/register_file_vectorial_stream.sv
// Vector register file: combinational dual read with write-first bypass, masked/broadcast
// full-vector write, and an FSM that fills one register element-per-beat from a stream.
module register_file_vectorial_stream #(
    parameter int WIDTH        = 32,
    parameter int VECTOR_SIZE  = 16,
    parameter int NUM_VECTORES = 8
) (
    input logic                            clk,
    input logic                            rst,
    register_file_vectorial_stream_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_VECTORES);
    localparam int CNT_W = $clog2(VECTOR_SIZE);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] tgt;
    logic             st_wr;

    logic [WIDTH-1:0] mem     [NUM_VECTORES][VECTOR_SIZE];
    logic [WIDTH-1:0] wr_lane [VECTOR_SIZE];

    always_comb begin
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            wr_lane[i] = bus.bcast ? bus.wd3[WIDTH-1:0] : bus.wd3[i*WIDTH +: WIDTH];
        end
    end

    // Serial beats are only consumed while in LOAD, where st_ready is held high.
    assign st_wr = (state == LOAD) && bus.st_valid;

    always_comb begin
        bus.vd1 = '0;
        bus.vd2 = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            bus.vd1[i*WIDTH +: WIDTH] = (bus.we3 && bus.wmask[i] && (bus.v3 == bus.v1))
                                        ? wr_lane[i] : mem[bus.v1][i];
            bus.vd2[i*WIDTH +: WIDTH] = (bus.we3 && bus.wmask[i] && (bus.v3 == bus.v2))
                                        ? wr_lane[i] : mem[bus.v2][i];
        end
    end

    // The vector port is checked first so it wins a same-lane collision with the serial port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_VECTORES; r++) begin
                for (int i = 0; i < VECTOR_SIZE; i++) begin
                    mem[r][i] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < NUM_VECTORES; r++) begin
                for (int i = 0; i < VECTOR_SIZE; i++) begin
                    if (bus.we3 && bus.wmask[i] && (bus.v3 == IDX_W'(r))) begin
                        mem[r][i] <= wr_lane[i];
                    end else if (st_wr && (tgt == IDX_W'(r)) && (cnt == CNT_W'(i))) begin
                        mem[r][i] <= bus.st_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tgt          <= '0;
            bus.st_ready <= 1'b0;
            bus.st_busy  <= 1'b0;
            bus.st_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.st_start) begin
                        state        <= LOAD;
                        tgt          <= bus.st_v;
                        cnt          <= '0;
                        bus.st_ready <= 1'b1;
                        bus.st_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.st_valid) begin
                        if (cnt == CNT_W'(VECTOR_SIZE - 1)) begin
                            state        <= DONE;
                            cnt          <= '0;
                            bus.st_ready <= 1'b0;
                            bus.st_done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.st_busy <= 1'b0;
                    bus.st_done <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.st_ready <= 1'b0;
                    bus.st_busy  <= 1'b0;
                    bus.st_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
